// File: rtl/conv_tap_sequencer.sv
// Convolution tap sequencer: walks ch/y/x/kr/kc for a 24-bit RGB image and
// emits one MAC tap (image byte address, kernel word address, pad flag) per handshake.
module conv_tap_sequencer (
  input  logic        Clk,
  input  logic        Reset_n,
  input  logic        Start,
  input  logic [31:0] ImageAddress,
  input  logic [31:0] kernelAddress,
  input  logic [15:0] ImageWidth,
  input  logic [15:0] ImageHeight,
  input  logic [3:0]  kernelSize,
  input  logic        TapReady,
  output logic        TapValid,
  output logic [31:0] TapImgAddr,
  output logic [31:0] TapKerAddr,
  output logic        TapPad,
  output logic        AccFirst,
  output logic        AccLast,
  output logic [1:0]  OutCh,
  output logic [15:0] OutX,
  output logic [15:0] OutY,
  output logic        Busy,
  output logic        Done,
  output logic        Err,
  output logic [1:0]  StateDbg
);

  // Handshake: a tap transfers on a rising Clk edge where TapValid && TapReady;
  // TapValid never drops and tap fields never change until that transfer.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SETUP = 2'd1,
    RUN   = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t state, stateNext;

  logic [31:0] imgBase, kerBase, rowBytes;
  logic [15:0] width, height;
  logic [3:0]  kSize, kCenter;
  logic        errFlag;
  logic [1:0]  ch;
  logic [15:0] x, y;
  logic [3:0]  kr, kc;

  logic        cfgErr, handshake, lastTap;
  logic        kcWrap, krWrap, xWrap, yWrap, chWrap;
  logic [31:0] rowCalc;
  logic signed [17:0] dx, dy;
  logic        pad;
  logic [31:0] imgCalc, kerCalc;

  assign cfgErr    = (width == 16'd0) || (height == 16'd0) || !kSize[0];
  assign handshake = (state == RUN) && TapReady;
  assign kcWrap    = (kc == kSize - 4'd1);
  assign krWrap    = (kr == kSize - 4'd1);
  assign xWrap     = (x == width - 16'd1);
  assign yWrap     = (y == height - 16'd1);
  assign chWrap    = (ch == 2'd2);
  assign lastTap   = chWrap && yWrap && xWrap && krWrap && kcWrap;
  assign rowCalc   = {16'd0, width} * 32'd3 + 32'd3;

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state <= IDLE;
    end else begin
      state <= stateNext;
    end
  end

  always_comb begin
    stateNext = state;
    case (state)
      IDLE:    if (Start) stateNext = SETUP;
      SETUP:   stateNext = cfgErr ? DONE : RUN;
      RUN:     if (handshake && lastTap) stateNext = DONE;
      DONE:    stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      imgBase  <= '0;
      kerBase  <= '0;
      width    <= '0;
      height   <= '0;
      kSize    <= '0;
      kCenter  <= '0;
      rowBytes <= '0;
      errFlag  <= 1'b0;
      ch       <= '0;
      x        <= '0;
      y        <= '0;
      kr       <= '0;
      kc       <= '0;
    end else begin
      if (state == IDLE && Start) begin
        imgBase <= ImageAddress;
        kerBase <= kernelAddress;
        width   <= ImageWidth;
        height  <= ImageHeight;
        kSize   <= kernelSize;
      end
      if (state == SETUP) begin
        kCenter  <= (kSize - 4'd1) >> 1;
        rowBytes <= rowCalc & ~32'd3;
        errFlag  <= cfgErr;
        ch       <= '0;
        x        <= '0;
        y        <= '0;
        kr       <= '0;
        kc       <= '0;
      end
      // Odometer: each counter wraps and carries only when all inner ones wrap.
      if (handshake) begin
        kc <= kcWrap ? 4'd0 : kc + 4'd1;
        if (kcWrap) kr <= krWrap ? 4'd0 : kr + 4'd1;
        if (kcWrap && krWrap) x <= xWrap ? 16'd0 : x + 16'd1;
        if (kcWrap && krWrap && xWrap) y <= yWrap ? 16'd0 : y + 16'd1;
        if (kcWrap && krWrap && xWrap && yWrap) ch <= chWrap ? 2'd0 : ch + 2'd1;
      end
    end
  end

  always_comb begin
    dx  = $signed({2'b00, x}) + $signed({14'd0, kc}) - $signed({14'd0, kCenter});
    dy  = $signed({2'b00, y}) + $signed({14'd0, kr}) - $signed({14'd0, kCenter});
    pad = dx[17] || dy[17] ||
          (dx >= $signed({2'b00, width})) || (dy >= $signed({2'b00, height}));
    // Only used when pad is clear, so dx/dy are non-negative and fit 16 bits.
    imgCalc = imgBase + {16'd0, dy[15:0]} * rowBytes + {16'd0, dx[15:0]} * 32'd3
            + {30'd0, ch};
    kerCalc = kerBase + {28'd0, kr} * {28'd0, kSize} + {28'd0, kc};
  end

  always_comb begin
    TapValid   = (state == RUN);
    TapPad     = TapValid && pad;
    TapImgAddr = (TapValid && !pad) ? imgCalc : 32'd0;
    TapKerAddr = TapValid ? kerCalc : 32'd0;
    AccFirst   = TapValid && (kr == 4'd0) && (kc == 4'd0);
    AccLast    = TapValid && krWrap && kcWrap;
    OutCh      = TapValid ? ch : 2'd0;
    OutX       = TapValid ? x : 16'd0;
    OutY       = TapValid ? y : 16'd0;
    Busy       = (state != IDLE);
    Done       = (state == DONE);
    Err        = Done && errFlag;
    StateDbg   = state;
  end

endmodule
